// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Holds the FSM state encoding, grant encoding and the idle write-enable pattern.
package dm_arb_pkg;

  typedef enum logic [0:0] {
    ST_CPU_PRIO  = 1'b0,
    ST_EXT_FORCE = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_EXT  = 2'd2
  } grant_e;

  localparam logic [3:0] WEB_IDLE = 4'hF;

  // Active-low byte enables: any low bit means a write.
  function automatic logic is_write(input logic [3:0] web);
    return ~&web;
  endfunction

endpackage

// File: rtl/dm_arb_perf_cnt.sv
// Saturating event counter used for arbiter performance statistics.
// Only instanced when DM_ARB_PERF_EN is defined.
module dm_arb_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;

  // Count events, holding at all-ones once saturated.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_r <= '0;
    end else if (inc_i && !(&cnt_r)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt_o = cnt_r;

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the no-delay data SRAM port between the CPU and an external requester,
// CPU first, with a starvation counter forcing one ext grant. Perf counters: DM_ARB_PERF_EN.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
`ifdef DM_ARB_PERF_EN
  output logic [CNT_W-1:0]  perf_stall_cnt_o,
  output logic [CNT_W-1:0]  perf_ext_cnt_o,
`endif
  input  logic              cpu_oe_i,
  input  logic [3:0]        cpu_web_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              ext_valid_i,
  input  logic [3:0]        ext_web_i,
  input  logic [ADDR_W-1:0] ext_addr_i,
  input  logic [DATA_W-1:0] ext_wdata_i,
  output logic              ext_ready_o,
  output logic              ext_rvalid_o,
  output logic [DATA_W-1:0] ext_rdata_o,
  output logic              DM_OE,
  output logic [ADDR_W-1:0] DM_A,
  output logic [3:0]        DM_WEB,
  output logic [DATA_W-1:0] DM_DI,
  input  logic [DATA_W-1:0] DM_DO
);

  localparam int              SC_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] SC_LIMIT = SC_W'(STARVE_LIMIT);
  localparam logic [SC_W-1:0] SC_ONE   = SC_W'(1);

  arb_state_e        state_r, state_s;
  logic [SC_W-1:0]   starve_cnt_r, starve_cnt_s;
  grant_e            gnt_s;
  logic              cpu_req_s;
  logic              ext_rd_s;
  logic              stall_s;
  logic              ext_rd_xfer_s;
  logic              ext_rvalid_r;
  logic [DATA_W-1:0] ext_rdata_r;

  // Arbitration FSM next state, starvation count and SRAM port mux.
  always_comb begin
    cpu_req_s     = cpu_oe_i | is_write(cpu_web_i);
    ext_rd_s      = ext_valid_i & (&ext_web_i);
    gnt_s         = GNT_NONE;
    stall_s       = 1'b0;
    state_s       = state_r;
    starve_cnt_s  = starve_cnt_r;
    DM_OE         = 1'b0;
    DM_A          = '0;
    DM_WEB        = WEB_IDLE;
    DM_DI         = '0;

    if (!rst_i) begin
      state_s      = ST_CPU_PRIO;
      starve_cnt_s = '0;
    end else begin
      case (state_r)
        ST_CPU_PRIO: begin
          if (cpu_req_s) begin
            gnt_s = GNT_CPU;
            // The blocked ext request earns one forced slot after STARVE_LIMIT losses.
            if (ext_valid_i) begin
              if (starve_cnt_r == (SC_LIMIT - SC_ONE)) begin
                state_s      = ST_EXT_FORCE;
                starve_cnt_s = '0;
              end else begin
                starve_cnt_s = starve_cnt_r + SC_ONE;
              end
            end else begin
              starve_cnt_s = '0;
            end
          end else if (ext_valid_i) begin
            gnt_s        = GNT_EXT;
            starve_cnt_s = '0;
          end else begin
            starve_cnt_s = '0;
          end
        end
        ST_EXT_FORCE: begin
          state_s      = ST_CPU_PRIO;
          starve_cnt_s = '0;
          if (ext_valid_i) begin
            gnt_s   = GNT_EXT;
            stall_s = cpu_req_s;
          end else if (cpu_req_s) begin
            gnt_s = GNT_CPU;
          end else begin
            gnt_s = GNT_NONE;
          end
        end
        default: begin
          state_s      = ST_CPU_PRIO;
          starve_cnt_s = '0;
        end
      endcase
    end

    case (gnt_s)
      GNT_CPU: begin
        DM_OE  = cpu_oe_i;
        DM_A   = cpu_addr_i;
        DM_WEB = cpu_web_i;
        DM_DI  = cpu_wdata_i;
      end
      GNT_EXT: begin
        DM_OE  = &ext_web_i;
        DM_A   = ext_addr_i;
        DM_WEB = ext_web_i;
        DM_DI  = ext_wdata_i;
      end
      default: begin
        DM_OE  = 1'b0;
        DM_WEB = WEB_IDLE;
      end
    endcase
  end

  assign ext_rd_xfer_s = (gnt_s == GNT_EXT) & ext_rd_s;

  // State, starvation counter and the registered ext read response.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r      <= ST_CPU_PRIO;
      starve_cnt_r <= '0;
      ext_rvalid_r <= 1'b0;
      ext_rdata_r  <= '0;
    end else begin
      state_r      <= state_s;
      starve_cnt_r <= starve_cnt_s;
      ext_rvalid_r <= ext_rd_xfer_s;
      if (ext_rd_xfer_s) begin
        ext_rdata_r <= DM_DO;
      end else begin
        ext_rdata_r <= ext_rdata_r;
      end
    end
  end

  assign cpu_rdata_o  = DM_DO;
  assign cpu_stall_o  = stall_s;
  assign ext_ready_o  = (gnt_s == GNT_EXT);
  assign ext_rvalid_o = ext_rvalid_r;
  assign ext_rdata_o  = ext_rdata_r;

`ifdef DM_ARB_PERF_EN
  dm_arb_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_s),
    .cnt_o (perf_stall_cnt_o)
  );

  dm_arb_perf_cnt #(.CNT_W(CNT_W)) u_ext_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (gnt_s == GNT_EXT),
    .cnt_o (perf_ext_cnt_o)
  );
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: directed scenarios plus random traffic
// compared against a cycle-level behavioural model and a reference memory.
`timescale 1ns/1ps
module tb_dm_port_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int SL     = 4;
`ifdef DM_ARB_PERF_EN
  localparam int CNT_W  = 3;
`else
  localparam int CNT_W  = 32;
`endif
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk_s = 1'b0;
  logic              rst_s = 1'b1;
  logic              cpu_oe_s = 1'b0;
  logic [3:0]        cpu_web_s = 4'hF;
  logic [ADDR_W-1:0] cpu_addr_s = '0;
  logic [DATA_W-1:0] cpu_wdata_s = '0;
  logic [DATA_W-1:0] cpu_rdata_s;
  logic              cpu_stall_s;
  logic              ext_valid_s = 1'b0;
  logic [3:0]        ext_web_s = 4'hF;
  logic [ADDR_W-1:0] ext_addr_s = '0;
  logic [DATA_W-1:0] ext_wdata_s = '0;
  logic              ext_ready_s;
  logic              ext_rvalid_s;
  logic [DATA_W-1:0] ext_rdata_s;
  logic              dm_oe_s;
  logic [ADDR_W-1:0] dm_a_s;
  logic [3:0]        dm_web_s;
  logic [DATA_W-1:0] dm_di_s;
  logic [DATA_W-1:0] dm_do_s;
`ifdef DM_ARB_PERF_EN
  logic [CNT_W-1:0]  perf_stall_s;
  logic [CNT_W-1:0]  perf_ext_s;
`endif

  logic [DATA_W-1:0] sram_mem [0:DEPTH-1];
  logic [DATA_W-1:0] ref_mem  [0:DEPTH-1];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int                blocked = 0;
  bit                force_pend = 1'b0;
  bit                exp_rvalid = 1'b0;
  logic [DATA_W-1:0] exp_rdata = '0;
  bit                last_egnt = 1'b0;
  bit                cur_stall = 1'b0;
  bit                cur_egnt = 1'b0;
  longint            exp_stall_cnt = 0;
  longint            exp_ext_cnt = 0;

  dm_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(SL), .CNT_W(CNT_W)
  ) dut (
    .clk_i            (clk_s),
    .rst_i            (rst_s),
`ifdef DM_ARB_PERF_EN
    .perf_stall_cnt_o (perf_stall_s),
    .perf_ext_cnt_o   (perf_ext_s),
`endif
    .cpu_oe_i         (cpu_oe_s),
    .cpu_web_i        (cpu_web_s),
    .cpu_addr_i       (cpu_addr_s),
    .cpu_wdata_i      (cpu_wdata_s),
    .cpu_rdata_o      (cpu_rdata_s),
    .cpu_stall_o      (cpu_stall_s),
    .ext_valid_i      (ext_valid_s),
    .ext_web_i        (ext_web_s),
    .ext_addr_i       (ext_addr_s),
    .ext_wdata_i      (ext_wdata_s),
    .ext_ready_o      (ext_ready_s),
    .ext_rvalid_o     (ext_rvalid_s),
    .ext_rdata_o      (ext_rdata_s),
    .DM_OE            (dm_oe_s),
    .DM_A             (dm_a_s),
    .DM_WEB           (dm_web_s),
    .DM_DI            (dm_di_s),
    .DM_DO            (dm_do_s)
  );

  always #5 clk_s = ~clk_s;

  // Zero-latency SRAM: combinational read, byte-enabled write on the clock edge.
  assign dm_do_s = sram_mem[dm_a_s];
  always @(posedge clk_s) begin
    for (int b = 0; b < 4; b++) begin
      if (!dm_web_s[b]) sram_mem[dm_a_s][8*b +: 8] <= dm_di_s[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                              input logic [DATA_W-1:0] new_v,
                                              input logic [3:0] web);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (!web[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  // Evaluate one cycle at the falling edge: predict from the rules, compare, commit.
  task automatic eval_cycle();
    bit creq, cgnt, egnt, was_force;
    @(negedge clk_s);
    if (!rst_s) begin
      blocked = 0; force_pend = 1'b0; exp_rvalid = 1'b0; exp_rdata = '0;
      last_egnt = 1'b0; cur_stall = 1'b0; cur_egnt = 1'b0;
      exp_stall_cnt = 0; exp_ext_cnt = 0;
      check("rst_ready", ext_ready_s, 1'b0);
      check("rst_stall", cpu_stall_s, 1'b0);
      check("rst_oe", dm_oe_s, 1'b0);
      check("rst_web", dm_web_s, 4'hF);
      check("rst_rvalid", ext_rvalid_s, 1'b0);
      check("rst_rdata", ext_rdata_s, 32'h0);
`ifdef DM_ARB_PERF_EN
      check("rst_perf_stall", perf_stall_s, 3'd0);
      check("rst_perf_ext", perf_ext_s, 3'd0);
`endif
      return;
    end
    creq = cpu_oe_s || (cpu_web_s != 4'hF);
    if (force_pend) begin
      egnt = ext_valid_s;
      cgnt = !ext_valid_s && creq;
    end else begin
      cgnt = creq;
      egnt = !creq && ext_valid_s;
    end
    cur_stall = egnt && creq;
    cur_egnt  = egnt;
    check("ready", ext_ready_s, egnt);
    check("stall", cpu_stall_s, cur_stall);
    check("rvalid", ext_rvalid_s, exp_rvalid);
    check("rdata", ext_rdata_s, exp_rdata);
`ifdef DM_ARB_PERF_EN
    check("perf_stall", perf_stall_s, exp_stall_cnt);
    check("perf_ext", perf_ext_s, exp_ext_cnt);
`endif
    if (cgnt) begin
      check("cpu_a", dm_a_s, cpu_addr_s);
      check("cpu_web", dm_web_s, cpu_web_s);
      check("cpu_oe", dm_oe_s, cpu_oe_s);
      if (cpu_oe_s) check("cpu_rdata", cpu_rdata_s, ref_mem[cpu_addr_s]);
      if (cpu_web_s != 4'hF) begin
        check("cpu_di", dm_di_s, cpu_wdata_s);
        ref_mem[cpu_addr_s] = merge(ref_mem[cpu_addr_s], cpu_wdata_s, cpu_web_s);
      end
    end else if (egnt) begin
      check("ext_a", dm_a_s, ext_addr_s);
      check("ext_web", dm_web_s, ext_web_s);
      check("ext_oe", dm_oe_s, ext_web_s == 4'hF);
      if (ext_web_s != 4'hF) begin
        check("ext_di", dm_di_s, ext_wdata_s);
        ref_mem[ext_addr_s] = merge(ref_mem[ext_addr_s], ext_wdata_s, ext_web_s);
      end
    end else begin
      check("idle_oe", dm_oe_s, 1'b0);
      check("idle_web", dm_web_s, 4'hF);
    end
    exp_rvalid = egnt && (ext_web_s == 4'hF);
    if (exp_rvalid) exp_rdata = ref_mem[ext_addr_s];
    if (egnt || !ext_valid_s) blocked = 0;
    else blocked++;
    was_force  = force_pend;
    force_pend = 1'b0;
    if (!was_force && blocked == SL) begin
      force_pend = 1'b1;
      blocked    = 0;
    end
    if (cur_stall && exp_stall_cnt < (64'd1 << CNT_W) - 1) exp_stall_cnt++;
    if (egnt && exp_ext_cnt < (64'd1 << CNT_W) - 1) exp_ext_cnt++;
    last_egnt = egnt;
  endtask

  task automatic advance();
    @(posedge clk_s);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      eval_cycle();
      advance();
    end
  endtask

  task automatic set_ext(input bit v, input logic [3:0] web, input int addr, input logic [31:0] d);
    ext_valid_s = v; ext_web_s = web; ext_addr_s = ADDR_W'(addr); ext_wdata_s = d;
  endtask

  task automatic set_cpu(input bit oe, input logic [3:0] web, input int addr, input logic [31:0] d);
    cpu_oe_s = oe; cpu_web_s = web; cpu_addr_s = ADDR_W'(addr); cpu_wdata_s = d;
  endtask

  task automatic rand_inputs();
    int r;
    r = $urandom_range(0, 5);
    if (r < 2) set_cpu(1'b0, 4'hF, 0, 32'h0);
    else if (r < 4) set_cpu(1'b1, 4'hF, $urandom_range(0, 63), $urandom);
    else set_cpu($urandom_range(0, 1), 4'($urandom_range(0, 14)), $urandom_range(0, 63), $urandom);
    if (!(ext_valid_s && !last_egnt)) begin
      if ($urandom_range(0, 2) == 0) set_ext(1'b0, 4'hF, 0, 32'h0);
      else if ($urandom_range(0, 1) == 0) set_ext(1'b1, 4'hF, $urandom_range(0, 63), 32'h0);
      else set_ext(1'b1, 4'($urandom_range(0, 14)), $urandom_range(0, 63), $urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      sram_mem[i] = (i * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
      ref_mem[i]  = (i * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    end
    sram_mem[16'h10] = 32'h0;        ref_mem[16'h10] = 32'h0;
    sram_mem[16'h20] = 32'h1234_5678; ref_mem[16'h20] = 32'h1234_5678;

    // Reset with an ext request pending: nothing may be granted.
    #2 rst_s = 1'b0;
    set_ext(1'b1, 4'hF, 32'h20, 32'h0);
    eval_cycle();
    advance();
    rst_s = 1'b1;
    set_ext(1'b0, 4'hF, 0, 32'h0);

    // 1: CPU-only partial write then read back.
    set_cpu(1'b0, 4'hC, 32'h10, 32'hAABB_CCDD);
    eval_cycle();
    check("t1_web", dm_web_s, 4'hC);
    check("t1_addr", dm_a_s, 14'h10);
    check("t1_stall", cpu_stall_s, 1'b0);
    advance();
    set_cpu(1'b1, 4'hF, 32'h10, 32'h0);
    eval_cycle();
    check("t1_rd", cpu_rdata_s, 32'h0000_CCDD);
    advance();

    // 2: ext-only read, response one cycle later.
    set_cpu(1'b0, 4'hF, 0, 32'h0);
    set_ext(1'b1, 4'hF, 32'h20, 32'h0);
    eval_cycle();
    check("t2_ready", ext_ready_s, 1'b1);
    advance();
    set_ext(1'b0, 4'hF, 0, 32'h0);
    eval_cycle();
    check("t2_rvalid", ext_rvalid_s, 1'b1);
    check("t2_rdata", ext_rdata_s, 32'h1234_5678);
    advance();
    eval_cycle();
    check("t2_pulse", ext_rvalid_s, 1'b0);
    advance();

    // 3: sustained contention, one forced ext slot every SL+1 cycles.
    set_cpu(1'b1, 4'hF, 32'h10, 32'h0);
    set_ext(1'b1, 4'hF, 32'h30, 32'h0);
    for (int i = 0; i < 15; i++) begin
      eval_cycle();
      check("t3_stall", cpu_stall_s, (i % 5) == 4);
      check("t3_ready", ext_ready_s, (i % 5) == 4);
      advance();
    end

    // 4: ext drops valid during the forced cycle.
    run(4);
    set_ext(1'b0, 4'hF, 0, 32'h0);
    eval_cycle();
    check("t4_stall", cpu_stall_s, 1'b0);
    check("t4_oe", dm_oe_s, 1'b1);
    check("t4_ready", ext_ready_s, 1'b0);
    advance();
    set_ext(1'b1, 4'hF, 32'h31, 32'h0);
    for (int i = 0; i < 5; i++) begin
      eval_cycle();
      check("t4_prio", ext_ready_s, i == 4);
      advance();
    end

    // 5: reset the cycle after an ext read transfer, with starvation partly built up.
    run(3);
    set_cpu(1'b0, 4'hF, 0, 32'h0);
    eval_cycle();
    check("t5_xfer", ext_ready_s, 1'b1);
    advance();
    rst_s = 1'b0;
    set_ext(1'b0, 4'hF, 0, 32'h0);
    eval_cycle();
    check("t5_rvalid", ext_rvalid_s, 1'b0);
    advance();
    rst_s = 1'b1;
    set_cpu(1'b1, 4'hF, 32'h11, 32'h0);
    set_ext(1'b1, 4'hF, 32'h32, 32'h0);
    for (int i = 0; i < 5; i++) begin
      eval_cycle();
      check("t5_after", cpu_stall_s, i == 4);
      advance();
    end

    // Random mixed traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      eval_cycle();
      advance();
    end

`ifdef DM_ARB_PERF_EN
    // 6: enough forced grants to saturate the narrow counters.
    set_cpu(1'b1, 4'hF, 32'h12, 32'h0);
    set_ext(1'b1, 4'hF, 32'h33, 32'h0);
    run(50);
    eval_cycle();
    check("t6_stall_sat", perf_stall_s, 3'd7);
    check("t6_ext_sat", perf_ext_s, 3'd7);
    advance();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
